// File: rtl/hdmi_rd_arbiter.sv
// Two-port arbiter sharing one DRAM read-address issue channel (kick/busy handshake).
// Port 0 (display prefetch) has bounded priority; a watchdog flags a stalled read master.
module hdmi_rd_arbiter #(
  parameter int unsigned PRIO0      = 1,
  parameter int unsigned MAX_BURST0 = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        req0_kick,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_num,
  output logic        req0_busy,
  input  logic        req1_kick,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_num,
  output logic        req1_busy,
  output logic        m_kick,
  input  logic        m_busy,
  output logic [31:0] m_read_addr,
  output logic [31:0] m_read_num,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_ACTIVE  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam logic [3:0]  C_MAX_BURST0 = 4'(MAX_BURST0);
  localparam logic [15:0] C_TIMEOUT    = 16'(TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_m_kick;
  logic [1:0]  r_grant;
  logic [31:0] r_addr;
  logic [31:0] r_num;
  logic        r_last_grant;   // 1 = port 1 was served last
  logic [3:0]  r_burst0_cnt;
  logic [15:0] r_wd_cnt;
  logic        r_timeout_err;
  logic        w_grant_evt;
  logic        w_pick1;
  logic [15:0] w_wd_inc;

  assign w_grant_evt = (r_state == S_IDLE) && (req0_kick || req1_kick);
  assign w_wd_inc    = r_wd_cnt + 16'd1;

  // Winner selection for the IDLE cycle in which a kick is sampled.
  always_comb begin
    w_pick1 = 1'b0;
    if (req0_kick && req1_kick) begin
      if (PRIO0 != 0) begin
        w_pick1 = (r_burst0_cnt == C_MAX_BURST0);
      end else begin
        w_pick1 = ~r_last_grant;
      end
    end else if (req1_kick) begin
      w_pick1 = 1'b1;
    end else begin
      w_pick1 = 1'b0;
    end
  end

  // Next-state logic of the issue FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_evt) w_state_nxt = S_ISSUE;
        else             w_state_nxt = S_IDLE;
      end
      S_ISSUE: begin
        if (m_busy) w_state_nxt = S_ACTIVE;
        else        w_state_nxt = S_ISSUE;
      end
      S_ACTIVE: begin
        if (!m_busy) w_state_nxt = S_RELEASE;
        else         w_state_nxt = S_ACTIVE;
      end
      S_RELEASE: w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Grant, latched request and master kick registers.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_m_kick     <= 1'b0;
      r_grant      <= 2'b00;
      r_addr       <= 32'd0;
      r_num        <= 32'd0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_grant_evt) begin
        r_m_kick     <= 1'b1;
        r_grant      <= w_pick1 ? 2'b10 : 2'b01;
        r_addr       <= w_pick1 ? req1_addr : req0_addr;
        r_num        <= w_pick1 ? req1_num  : req0_num;
        r_last_grant <= w_pick1;
      end else if (r_state == S_ISSUE && m_busy) begin
        r_m_kick <= 1'b0;
      end else if (r_state == S_RELEASE) begin
        r_grant <= 2'b00;
      end
    end
  end

  // Consecutive port-0 wins counted only while port 1 is being held off.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_burst0_cnt <= 4'd0;
    end else if (w_grant_evt) begin
      if (w_pick1) begin
        r_burst0_cnt <= 4'd0;
      end else if (req1_kick && (r_burst0_cnt < C_MAX_BURST0)) begin
        r_burst0_cnt <= r_burst0_cnt + 4'd1;
      end
    end
  end

  // Watchdog: counts ISSUE cycles; the error flag is sticky until reset.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      r_wd_cnt      <= 16'd0;
      r_timeout_err <= 1'b0;
    end else if (w_grant_evt) begin
      r_wd_cnt <= 16'd0;
    end else if (r_state == S_ISSUE) begin
      if (r_wd_cnt != 16'hFFFF) r_wd_cnt <= w_wd_inc;
      if (w_wd_inc == C_TIMEOUT) r_timeout_err <= 1'b1;
    end
  end

  assign m_kick      = r_m_kick;
  assign grant       = r_grant;
  assign m_read_addr = r_addr;
  assign m_read_num  = r_num;
  assign timeout_err = r_timeout_err;
  assign req0_busy   = r_grant[0] & m_busy;
  assign req1_busy   = r_grant[1] & m_busy;

endmodule

// File: tb/tb_hdmi_rd_arbiter.sv
// Directed bench for hdmi_rd_arbiter: a priority instance and a round-robin instance
// share all inputs; expected values come from hand-built tables and sequences.
module tb_hdmi_rd_arbiter;

  logic        clk_vga = 1'b0;
  logic        rst_n   = 1'b0;
  logic        req0_kick = 1'b0, req1_kick = 1'b0, m_busy = 1'b0;
  logic [31:0] req0_addr = 32'd0, req0_num = 32'd0;
  logic [31:0] req1_addr = 32'd0, req1_num = 32'd0;

  logic        req0_busy, req1_busy, m_kick, timeout_err;
  logic [31:0] m_read_addr, m_read_num;
  logic [1:0]  grant;
  logic        rr_req0_busy, rr_req1_busy, rr_m_kick, rr_timeout_err;
  logic [31:0] rr_m_read_addr, rr_m_read_num;
  logic [1:0]  rr_grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_vga = ~clk_vga;

  hdmi_rd_arbiter #(.PRIO0(1), .MAX_BURST0(4), .TIMEOUT(8)) u_dut (
    .clk_vga(clk_vga), .rst_n(rst_n),
    .req0_kick(req0_kick), .req0_addr(req0_addr), .req0_num(req0_num), .req0_busy(req0_busy),
    .req1_kick(req1_kick), .req1_addr(req1_addr), .req1_num(req1_num), .req1_busy(req1_busy),
    .m_kick(m_kick), .m_busy(m_busy), .m_read_addr(m_read_addr), .m_read_num(m_read_num),
    .grant(grant), .timeout_err(timeout_err)
  );

  hdmi_rd_arbiter #(.PRIO0(0), .MAX_BURST0(4), .TIMEOUT(8)) u_dut_rr (
    .clk_vga(clk_vga), .rst_n(rst_n),
    .req0_kick(req0_kick), .req0_addr(req0_addr), .req0_num(req0_num), .req0_busy(rr_req0_busy),
    .req1_kick(req1_kick), .req1_addr(req1_addr), .req1_num(req1_num), .req1_busy(rr_req1_busy),
    .m_kick(rr_m_kick), .m_busy(m_busy), .m_read_addr(rr_m_read_addr), .m_read_num(rr_m_read_num),
    .grant(rr_grant), .timeout_err(rr_timeout_err)
  );

  typedef struct {
    logic       busy_drv;
    logic       exp_kick;
    logic [1:0] exp_grant;
    logic       exp_rb;
  } t1_vec_t;

  typedef struct {
    logic [1:0]  g_prio;
    logic [1:0]  g_rr;
    logic [31:0] addr_prio;
  } t2_vec_t;

  t1_vec_t t1 [13];
  t2_vec_t t2 [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic wait_kick(input string nm);
    int n = 0;
    while (m_kick !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, m_kick}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    localparam logic [31:0] A0 = 32'hA000_0000;
    localparam logic [31:0] A1 = 32'hB000_0000;

    t1[0]  = '{1'b0, 1'b1, 2'b01, 1'b0};
    t1[1]  = '{1'b0, 1'b1, 2'b01, 1'b0};
    t1[2]  = '{1'b1, 1'b1, 2'b01, 1'b1};
    t1[3]  = '{1'b1, 1'b0, 2'b01, 1'b1};
    t1[4]  = '{1'b1, 1'b0, 2'b01, 1'b1};
    t1[5]  = '{1'b1, 1'b0, 2'b01, 1'b1};
    t1[6]  = '{1'b1, 1'b0, 2'b01, 1'b1};
    t1[7]  = '{1'b1, 1'b0, 2'b01, 1'b1};
    t1[8]  = '{1'b1, 1'b0, 2'b01, 1'b1};
    t1[9]  = '{1'b0, 1'b0, 2'b01, 1'b0};
    t1[10] = '{1'b0, 1'b0, 2'b01, 1'b0};
    t1[11] = '{1'b0, 1'b0, 2'b00, 1'b0};
    t1[12] = '{1'b0, 1'b0, 2'b00, 1'b0};

    for (int i = 0; i < 10; i++) begin
      t2[i].g_prio    = ((i % 5) == 4) ? 2'b10 : 2'b01;
      t2[i].g_rr      = ((i % 2) == 1) ? 2'b10 : 2'b01;
      t2[i].addr_prio = ((i % 5) == 4) ? A1 : A0;
    end

    // Reset values
    do_reset();
    chk("rst_m_kick", {31'd0, m_kick}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_addr", m_read_addr, 32'd0);
    chk("rst_num", m_read_num, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);

    // Single requester, per-edge table
    req0_kick = 1'b1;
    req0_addr = 32'h0000_0400;
    req0_num  = 32'd64;
    for (int e = 0; e < 13; e++) begin
      tick();
      chk($sformatf("t1_kick_e%0d", e + 1), {31'd0, m_kick}, {31'd0, t1[e].exp_kick});
      chk($sformatf("t1_grant_e%0d", e + 1), {30'd0, grant}, {30'd0, t1[e].exp_grant});
      if (e == 0) req0_kick = 1'b0;
      m_busy = t1[e].busy_drv;
      #1;
      chk($sformatf("t1_rbusy_e%0d", e + 1), {31'd0, req0_busy}, {31'd0, t1[e].exp_rb});
    end
    chk("t1_addr", m_read_addr, 32'h0000_0400);
    chk("t1_num", m_read_num, 32'd64);
    chk("t1_timeout", {31'd0, timeout_err}, 32'd0);

    // Both ports kicking continuously: bounded priority vs round robin
    do_reset();
    req0_kick = 1'b1; req0_addr = A0; req0_num = 32'd10;
    req1_kick = 1'b1; req1_addr = A1; req1_num = 32'd20;
    for (int i = 0; i < 10; i++) begin
      wait_kick($sformatf("t2_kick_%0d", i));
      chk($sformatf("t2_grant_prio_%0d", i), {30'd0, grant}, {30'd0, t2[i].g_prio});
      chk($sformatf("t2_grant_rr_%0d", i), {30'd0, rr_grant}, {30'd0, t2[i].g_rr});
      chk($sformatf("t2_addr_prio_%0d", i), m_read_addr, t2[i].addr_prio);
      m_busy = 1'b1;
      tick();
      tick();
      m_busy = 1'b0;
      tick();
    end
    req0_kick = 1'b0;
    req1_kick = 1'b0;

    // Port 1 owns the channel; late changes and a port-0 kick must not disturb it
    do_reset();
    req1_kick = 1'b1; req1_addr = 32'h1111_0000; req1_num = 32'd16;
    wait_kick("t4_kick1");
    chk("t4_grant1", {30'd0, grant}, 32'd2);
    req1_kick = 1'b0;
    m_busy = 1'b1;
    tick();
    tick();
    req1_addr = 32'h2222_0000;
    req0_kick = 1'b1; req0_addr = 32'h3333_0000; req0_num = 32'd8;
    tick();
    chk("t4_addr_hold", m_read_addr, 32'h1111_0000);
    chk("t4_req0_busy", {31'd0, req0_busy}, 32'd0);
    chk("t4_req1_busy", {31'd0, req1_busy}, 32'd1);
    m_busy = 1'b0;
    tick();
    chk("t4_release_grant", {30'd0, grant}, 32'd2);
    tick();
    chk("t4_idle_grant", {30'd0, grant}, 32'd0);
    chk("t4_idle_kick", {31'd0, m_kick}, 32'd0);
    tick();
    chk("t4_grant0", {30'd0, grant}, 32'd1);
    chk("t4_kick0", {31'd0, m_kick}, 32'd1);
    chk("t4_addr0", m_read_addr, 32'h3333_0000);
    req0_kick = 1'b0;

    // Watchdog with m_busy held low in ISSUE
    for (int i = 0; i < 7; i++) tick();
    chk("t5_err_pre", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("t5_err_set", {31'd0, timeout_err}, 32'd1);
    chk("t5_kick_held", {31'd0, m_kick}, 32'd1);
    tick();
    chk("t5_err_sticky_issue", {31'd0, timeout_err}, 32'd1);
    m_busy = 1'b1;
    tick();
    chk("t5_kick_drop", {31'd0, m_kick}, 32'd0);
    m_busy = 1'b0;
    tick();
    tick();
    chk("t5_idle_grant", {30'd0, grant}, 32'd0);
    chk("t5_err_sticky_idle", {31'd0, timeout_err}, 32'd1);

    // Asynchronous reset in ACTIVE, then a fresh port-1 request
    req1_kick = 1'b1; req1_addr = 32'h5555_0000; req1_num = 32'd3;
    wait_kick("t6_kick");
    m_busy = 1'b1;
    tick();
    tick();
    chk("t6_grant_active", {30'd0, grant}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_kick", {31'd0, m_kick}, 32'd0);
    chk("t6_rst_grant", {30'd0, grant}, 32'd0);
    chk("t6_rst_addr", m_read_addr, 32'd0);
    chk("t6_rst_num", m_read_num, 32'd0);
    chk("t6_rst_err", {31'd0, timeout_err}, 32'd0);
    chk("t6_rst_busy1", {31'd0, req1_busy}, 32'd0);
    m_busy = 1'b0;
    req1_kick = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req1_kick = 1'b1; req1_addr = 32'h6666_0000; req1_num = 32'd5;
    wait_kick("t6_kick_after");
    chk("t6_grant_after", {30'd0, grant}, 32'd2);
    chk("t6_addr_after", m_read_addr, 32'h6666_0000);
    chk("t6_num_after", m_read_num, 32'd5);
    req1_kick = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hdmi_rd_arbiter.md
Name: hdmi_rd_arbiter

Overview:
- Two-port arbiter that shares the single DRAM read-address issue channel (kick/busy/read_addr/read_num) between requesters.
- Port 0 is the HDMI line prefetcher; port 1 is a secondary reader, such as an overlay or DMA fetch.
- Each port uses the same kick/busy handshake that the downstream master presents, so requesters connect unmodified.
- Port 0 has bounded priority so the display cannot starve port 1, and a watchdog flags a stalled downstream master.

Parameters:
- PRIO0, 1: 1 means port 0 wins ties, subject to MAX_BURST0; 0 means pure round-robin.
- MAX_BURST0, 4: maximum consecutive port-0 grants while port 1 is pending (range 1..15).
- TIMEOUT, 1024: cycles allowed in ISSUE for m_busy to rise before timeout_err sets (16-bit counter).

Ports:
- clk_vga, input, 1: clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req0_kick, input, 1: port 0 request.
- req0_addr, input, 32: port 0 byte address.
- req0_num, input, 32: port 0 word count.
- req0_busy, output, 1: port 0 busy.
- req1_kick, input, 1: port 1 request.
- req1_addr, input, 32: port 1 byte address.
- req1_num, input, 32: port 1 word count.
- req1_busy, output, 1: port 1 busy.
- m_kick, output, 1: kick to the read master.
- m_busy, input, 1: busy from the read master.
- m_read_addr, output, 32: latched address.
- m_read_num, output, 32: latched word count.
- grant, output, 2: one-hot current owner; 00 when idle.
- timeout_err, output, 1: sticky watchdog flag.

Behaviour:
- Reset (rst_n low, asynchronous) forces these values:
  - state IDLE;
  - m_kick, grant, m_read_addr, m_read_num and timeout_err all 0;
  - burst0_cnt 0;
  - last_grant set to port 1, so port 0 wins the first round-robin tie.
- States and transitions:
  - IDLE → ISSUE when any reqX_kick is 1.
  - ISSUE → ACTIVE when m_busy is 1.
  - ACTIVE → RELEASE when m_busy is 0.
  - RELEASE → IDLE unconditionally; RELEASE lasts exactly 1 cycle.
- Grant selection happens in IDLE, on the cycle where a kick is sampled:
  - Only req0 kicking: grant port 0.
  - Only req1 kicking: grant port 1.
  - Both kicking, PRIO0=1: port 0 unless burst0_cnt==MAX_BURST0, in which case port 1.
  - Both kicking, PRIO0=0: the port that is not last_grant.
- On grant, in the same edge:
  - the IDLE→ISSUE transition;
  - grant set one-hot;
  - m_read_addr/m_read_num latched from the winner;
  - last_grant updated.
- Latency: a kick sampled at edge N gives m_kick=1 after edge N.
- m_kick is 1 in ISSUE only. It falls on the edge at which m_busy is sampled 1.
- reqX_busy = grant[X] & m_busy, combinational.
  - A non-granted requester sees busy=0 and keeps kicking until it is served.
  - Its request stays pending; requests are never queued internally.
- Changes to a granted requester's kick, addr or num after grant are ignored (values are latched).
- A kick withdrawn before being granted is simply not served.
- grant clears on the RELEASE→IDLE edge. A kick re-asserted during RELEASE is sampled in the following IDLE cycle.
- Minimum spacing between grants: 1 IDLE cycle.
- burst0_cnt behaviour:
  - increments (saturating at MAX_BURST0) on a port-0 grant made while req1_kick=1;
  - clears on any port-1 grant;
  - holds on a port-0 grant made with req1_kick=0.
- Watchdog:
  - a 16-bit counter clears on entering ISSUE and increments each ISSUE cycle;
  - when it reaches TIMEOUT, timeout_err is set;
  - timeout_err is sticky until reset;
  - the FSM keeps waiting in ISSUE; the transaction is not aborted.
- m_busy already 1 on the first ISSUE cycle: accepted, go to ACTIVE next edge (m_kick high for 1 cycle).
- m_busy falling in ISSUE before it was ever seen high: no effect.
- Reset asserted mid-transaction: immediate return to reset values. The requester recovers through its own reset.

Test Plan:
1. Single requester: req0_kick=1 with addr=0x400, num=64 at edge 0; m_busy=1 at edge 3, 0 at edge 10.
   - m_kick is high for edges 1–3.
   - m_read_addr=0x400 and m_read_num=64.
   - grant=01 from edge 1 to edge 11.
   - req0_busy mirrors m_busy over edges 3–10.
2. Simultaneous kicks with PRIO0=1 and MAX_BURST0=4, both ports kicking continuously:
   - grant sequence is 0,0,0,0,1,0,0,0,0,1.
   - req1 addr appears on m_read_addr on every 5th grant.
3. PRIO0=0, both ports kicking continuously:
   - grants alternate 0,1,0,1.
   - the first grant after reset is port 0.
4. Port 1 granted, then req1_addr changes and req0_kick rises during ACTIVE:
   - m_read_addr holds the port-1 value.
   - req0_busy stays 0.
   - port 0 is granted in the first IDLE cycle after RELEASE.
5. TIMEOUT=8, m_busy held 0:
   - timeout_err rises after 8 ISSUE cycles and m_kick remains 1.
   - m_busy=1 later completes normally; timeout_err stays 1 until rst_n is low.
6. rst_n pulsed low asynchronously while in ACTIVE:
   - all outputs are 0 within the same cycle.
   - after release, a fresh req1 kick is granted normally.
